// File: rtl/input_buffer.sv
// SHA-256 message-block loader: a 16-word staging bank written by address,
// double-buffered into a holding bank offered to the core with valid/ready.
module input_buffer (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [4:0]   addr,
   input  logic [31:0]  in_var,
   input  logic         we,
   input  logic         commit,
   input  logic         in_last,
   input  logic         block_ready,
   output logic [511:0] out_block,
   output logic         block_valid,
   output logic         block_last,
   output logic         stage_full,
   output logic [4:0]   wr_cnt,
   output logic         commit_err
);

   typedef enum logic [0:0] {
      ST_EMPTY  = 1'b0,
      ST_LOADED = 1'b1
   } hold_state_e;

   function automatic logic [4:0] popcount16(input logic [15:0] m);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, m[i]};
      end
      return cnt;
   endfunction

   logic [31:0]  stage_q [16];
   logic [15:0]  mask_q;
   logic [511:0] hold_q;
   logic         last_q;
   logic         err_q;
   hold_state_e  state_q;

   logic         addr_ok_s;
   logic [4:0]   idx_full_s;
   logic [3:0]   wr_idx_s;
   logic         wr_hit_s;
   logic         commit_ok_s;
   logic         commit_rej_s;
   logic [511:0] stage_flat_s;

   // Decode the write address and the commit acceptance condition
   always_comb begin
      addr_ok_s    = (addr != 5'd0) && (addr <= 5'd16);
      idx_full_s   = addr - 5'd1;
      wr_idx_s     = idx_full_s[3:0];
      wr_hit_s     = we && addr_ok_s;
      commit_ok_s  = commit && stage_full && ((state_q == ST_EMPTY) || block_ready);
      commit_rej_s = commit && !commit_ok_s;
   end

   // Flatten staging words so W0 lands in the most significant slot
   always_comb begin
      stage_flat_s = 512'd0;
      for (int i = 0; i < 16; i++) begin
         stage_flat_s[511 - 32*i -: 32] = stage_q[i];
      end
   end

   // Staging bank: a write coinciding with an accepted commit survives in the cleared mask
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            stage_q[i] <= 32'd0;
         end
         mask_q <= 16'd0;
      end else begin
         if (wr_hit_s) begin
            stage_q[wr_idx_s] <= in_var;
         end
         if (commit_ok_s) begin
            mask_q <= wr_hit_s ? (16'd1 << wr_idx_s) : 16'd0;
         end else if (wr_hit_s) begin
            mask_q[wr_idx_s] <= 1'b1;
         end
      end
   end

   // Holding bank FSM with registered block, last flag and reject pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         hold_q  <= 512'd0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= commit_rej_s;
         case (state_q)
            ST_EMPTY: begin
               if (commit_ok_s) begin
                  state_q <= ST_LOADED;
                  hold_q  <= stage_flat_s;
                  last_q  <= in_last;
               end
            end
            ST_LOADED: begin
               if (commit_ok_s) begin
                  hold_q <= stage_flat_s;
                  last_q <= in_last;
               end else if (block_ready) begin
                  state_q <= ST_EMPTY;
                  last_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_EMPTY;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_block   = hold_q;
   assign block_valid = (state_q == ST_LOADED);
   assign block_last  = last_q;
   assign stage_full  = (mask_q == 16'hFFFF);
   assign wr_cnt      = popcount16(mask_q);
   assign commit_err  = err_q;

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer; expectations queue up as stimulus is driven.
module tb_input_buffer;

   logic         clk;
   logic         rst_n;
   logic [4:0]   addr;
   logic [31:0]  in_var;
   logic         we;
   logic         commit;
   logic         in_last;
   logic         block_ready;
   logic [511:0] out_block;
   logic         block_valid;
   logic         block_last;
   logic         stage_full;
   logic [4:0]   wr_cnt;
   logic         commit_err;

   input_buffer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .addr        (addr),
      .in_var      (in_var),
      .we          (we),
      .commit      (commit),
      .in_last     (in_last),
      .block_ready (block_ready),
      .out_block   (out_block),
      .block_valid (block_valid),
      .block_last  (block_last),
      .stage_full  (stage_full),
      .wr_cnt      (wr_cnt),
      .commit_err  (commit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        tag;
      logic [511:0] val;
   } exp_t;

   exp_t         sb_q [$];
   int           errors = 0;
   int           checks = 0;
   logic [31:0]  mw [16];
   logic [511:0] held;
   logic [511:0] snap;

   function automatic logic [511:0] pack_model();
      logic [511:0] r;
      r = 512'd0;
      for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = mw[i];
      return r;
   endfunction

   task automatic push_exp(input string tag, input logic [511:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic check(input logic [511:0] obs);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL sb_empty: observed=%0h expected=<queued value>", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val)
         else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      addr = a; in_var = d; we = 1'b1;
      if (a >= 5'd1 && a <= 5'd16) mw[a - 5'd1] = d;
      step();
      we = 1'b0;
   endtask

   task automatic fill(input logic [31:0] base, input logic [4:0] skip);
      for (int i = 1; i <= 16; i++) begin
         if (i[4:0] != skip) wr(i[4:0], base + i);
      end
   endtask

   initial begin
      rst_n = 1'b0; addr = 5'd0; in_var = 32'd0; we = 1'b0;
      commit = 1'b0; in_last = 1'b0; block_ready = 1'b0;
      for (int i = 0; i < 16; i++) mw[i] = 32'd0;
      held = 512'd0;
      repeat (3) @(negedge clk);
      push_exp("rst_valid", 512'd0);  push_exp("rst_cnt", 512'd0);
      push_exp("rst_full", 512'd0);   push_exp("rst_err", 512'd0);
      push_exp("rst_block", 512'd0);
      check(block_valid); check(wr_cnt); check(stage_full); check(commit_err); check(out_block);
      rst_n = 1'b1;
      step();

      // Full load, commit with in_last
      fill(32'h0, 5'd0);
      push_exp("t1_cnt16", 512'd16); push_exp("t1_full", 512'd1);
      check(wr_cnt); check(stage_full);
      commit = 1'b1; in_last = 1'b1;
      held = pack_model();
      push_exp("t1_valid", 512'd1); push_exp("t1_last", 512'd1);
      push_exp("t1_w0", 512'h1); push_exp("t1_w15", 512'h10);
      push_exp("t1_block", held); push_exp("t1_cnt0", 512'd0); push_exp("t1_err", 512'd0);
      step();
      commit = 1'b0; in_last = 1'b0;
      check(block_valid); check(block_last);
      check(out_block[511:480]); check(out_block[31:0]);
      check(out_block); check(wr_cnt); check(commit_err);

      // Consume, then ready while empty is ignored
      block_ready = 1'b1;
      push_exp("cons_valid", 512'd0); push_exp("cons_last", 512'd0); push_exp("cons_stale", held);
      step();
      check(block_valid); check(block_last); check(out_block);
      push_exp("idle_ready_valid", 512'd0);
      step();
      block_ready = 1'b0;
      check(block_valid);

      // Partial load rejected, then completed
      fill(32'h100, 5'd16);
      commit = 1'b1;
      push_exp("t2_err", 512'd1); push_exp("t2_valid", 512'd0); push_exp("t2_cnt15", 512'd15);
      step();
      commit = 1'b0;
      check(commit_err); check(block_valid); check(wr_cnt);
      push_exp("t2_err_pulse", 512'd0);
      step();
      check(commit_err);
      wr(5'd16, 32'h110);
      commit = 1'b1;
      held = pack_model();
      push_exp("t2_valid_acc", 512'd1); push_exp("t2_last0", 512'd0); push_exp("t2_block", held);
      step();
      commit = 1'b0;
      check(block_valid); check(block_last); check(out_block);

      // Holding busy: commit rejected while not ready, accepted with ready
      fill(32'h200, 5'd0);
      commit = 1'b1;
      push_exp("t3_err", 512'd1); push_exp("t3_unchanged", held);
      push_exp("t3_valid", 512'd1); push_exp("t3_cnt16", 512'd16);
      step();
      check(commit_err); check(out_block); check(block_valid); check(wr_cnt);
      block_ready = 1'b1;
      held = pack_model();
      push_exp("t3_valid_kept", 512'd1); push_exp("t3_new", held); push_exp("t3_err0", 512'd0);
      step();
      check(block_valid); check(out_block); check(commit_err);

      // Accepted commit together with a write to addr 3
      fill(32'h300, 5'd0);
      held = pack_model();
      we = 1'b1; addr = 5'd3; in_var = 32'hDEADBEEF;
      push_exp("t4_w2_old", 512'h303); push_exp("t4_block", held);
      push_exp("t4_cnt1", 512'd1); push_exp("t4_full0", 512'd0);
      step();
      we = 1'b0; commit = 1'b0;
      mw[2] = 32'hDEADBEEF;
      check(out_block[447:416]); check(out_block); check(wr_cnt); check(stage_full);
      fill(32'h400, 5'd3);
      push_exp("t4_cnt16", 512'd16);
      check(wr_cnt);
      commit = 1'b1;
      held = pack_model();
      push_exp("t4_w2_new", 512'hDEADBEEF); push_exp("t4_block2", held);
      step();
      commit = 1'b0;
      check(out_block[447:416]); check(out_block);

      // Invalid addresses ignored, rewrites keep the mask bit
      wr(5'd0, 32'hAAAA0000);
      wr(5'd20, 32'hBBBB0000);
      push_exp("t5_cnt0", 512'd0);
      check(wr_cnt);
      wr(5'd5, 32'h11111111);
      wr(5'd5, 32'h22222222);
      push_exp("t5_cnt1", 512'd1);
      check(wr_cnt);
      fill(32'h500, 5'd5);
      commit = 1'b1;
      held = pack_model();
      push_exp("t5_w4", 512'h22222222); push_exp("t5_block", held);
      step();
      commit = 1'b0; block_ready = 1'b0;
      check(out_block[383:352]); check(out_block);

      // Asynchronous reset while loaded with 7 staged words
      for (int i = 1; i <= 7; i++) wr(i[4:0], 32'h600 + i);
      push_exp("t6_cnt7", 512'd7); push_exp("t6_valid1", 512'd1);
      check(wr_cnt); check(block_valid);
      #2;
      rst_n = 1'b0;
      #1;
      snap = out_block;
      push_exp("ar_valid", 512'd0); push_exp("ar_last", 512'd0); push_exp("ar_cnt", 512'd0);
      push_exp("ar_full", 512'd0); push_exp("ar_err", 512'd0); push_exp("ar_block", 512'd0);
      check(block_valid); check(block_last); check(wr_cnt);
      check(stage_full); check(commit_err); check(snap);
      #10;
      rst_n = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/input_buffer.md
# input_buffer

Host-side message-block loader for the SHA-256 core; the write-path counterpart of the hash output buffer. The host writes sixteen 32-bit message words one at a time by address into a staging bank, then commits them. The block moves to a holding bank and is offered to the hash core as one 512-bit block with a valid/ready handshake. Double buffering lets the host load block N+1 while the core consumes block N.

## Interface
Parameters: none.

Ports:
- clk  in  1  single system clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- addr  in  5  word address; 1..16 select W0..W15; 0 and 17..31 are no-op
- in_var  in  32  write data
- we  in  1  write strobe; writes in_var to staging word addr
- commit  in  1  request transfer of staging bank to holding bank
- in_last  in  1  sampled with an accepted commit; marks final message block
- block_ready  in  1  hash core accepts holding block
- out_block  out  512  holding bank; W0 at [511:480], W15 at [31:0]
- block_valid  out  1  holding bank holds an unconsumed block
- block_last  out  1  in_last captured with the current holding block
- stage_full  out  1  all 16 staging words written since last accepted commit
- wr_cnt  out  5  number of distinct staging words written (0..16)
- commit_err  out  1  one-cycle pulse: commit rejected

## Operation
- Staging bank: 16 x 32-bit words plus 16-bit written mask. A write with valid addr stores in_var and sets the mask bit. Rewriting a word overwrites the data and leaves the mask unchanged. Writes with invalid addr change nothing.
- stage_full = mask all ones. wr_cnt = popcount(mask).
- Commit is accepted iff stage_full and (block_valid == 0, or block_ready == 1 in the same cycle).
- On an accepted commit:
  - The staging words are copied to out_block.
  - block_valid is set; block_last is set to in_last.
  - The mask is cleared.
- Rejected commit: no state change except a commit_err pulse. The staging data and mask are kept.
- Consume: block_valid && block_ready at an edge clears block_valid and block_last. out_block keeps its stale data. With no accepted commit, nothing else changes.
- Consume and accepted commit in the same cycle: the holding bank is reloaded and block_valid stays 1 with no gap.
- we and accepted commit in the same cycle:
  - The commit copies the pre-write staging contents.
  - The write lands in the freshly cleared staging bank, so the mask after the edge has only that word's bit set.
- we and rejected commit in the same cycle: the write proceeds normally.
- block_ready while block_valid = 0 is ignored.
- Two-state view of the holding bank: EMPTY (block_valid 0) and LOADED (block_valid 1).
  - EMPTY -> LOADED on an accepted commit.
  - LOADED -> EMPTY on consume without a commit.
  - LOADED -> LOADED on consume plus commit.

## Timing
- Reset (async assert, sync release on clk): all staging words 0, mask 0, out_block 0, block_valid 0, block_last 0, commit_err 0. Hence stage_full 0 and wr_cnt 0.
- Reset mid-operation discards both banks immediately. Any in-flight handshake is dropped.
- Write at edge N: the word and mask are updated after N. stage_full and wr_cnt reflect the write from cycle N+1.
- Commit at edge N: out_block, block_valid and block_last are valid in cycle N+1. Write-to-core latency is therefore 1 cycle after the final word's commit.
- commit_err is registered: high for exactly cycle N+1 after a rejected commit at edge N.
- All outputs are registered or derived from registers only. There is no combinational path from inputs to outputs.

## Test plan
- Reset, write addr 1..16 with data 0x00000001..0x00000010, commit with in_last=1 -> next cycle block_valid=1, block_last=1, out_block[511:480]=0x00000001, out_block[31:0]=0x00000010, wr_cnt=0.
- Write only addr 1..15 then commit -> commit_err high one cycle; block_valid=0; wr_cnt stays 15. Write addr 16 and commit -> accepted.
- Holding LOADED with block_ready=0; fill staging and commit -> commit_err=1, out_block unchanged. Repeat the commit with block_ready=1 -> block_valid stays 1 and out_block shows the new block.
- Same cycle: accepted commit plus we to addr 3 with 0xDEADBEEF -> out_block word W2 keeps its old value; staging mask has only bit 2 set; wr_cnt=1.
- Write addr 0 and addr 20, then rewrite addr 5 twice -> wr_cnt=1; the last addr-5 value appears at out_block[383:352] after the block is completed and committed.
- Assert rst_n low while block_valid=1 and wr_cnt=7 -> all outputs 0 immediately, without waiting for clk.
